axi3_wr_arbiter: RTL and testbench

- Shares one AXI3 master write port (AW/W/B channels) between NUM_REQ requesters.
- Grants by round-robin and locks the grant for one full transaction (address, all data beats, response).
- Muxes the granted requester's fields onto the master port and generates WLast from a beat counter.
- Sits between the CPU-side requesters and the Master_AXI3 channel logic.

---
 rtl/axi3_arb_pkg.sv | 20 ++
 rtl/axi3_wr_arbiter_rr_pick.sv | 29 ++
 rtl/axi3_wr_arbiter.sv | 176 +++++++++++++++++
 tb/tb_axi3_wr_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi3_arb_pkg.sv
// Shared types and constants for the AXI3 write-port arbiter.
// Holds the FSM state encoding, the BRESP codes and the default field widths.
package axi3_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam int DEF_LEN_W = 4;
    localparam int DEF_ID_W  = 4;

endpackage

// File: rtl/axi3_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: the first asserted request at or after ptr,
// wrapping modulo NUM_REQ, returned one-hot together with an any-request flag.
module rr_pick
    import axi3_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               any
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        pick = '0;
        any  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!any && req_valid[j] && (j == (int'(ptr) + i) % NUM_REQ)) begin
                    pick[j] = 1'b1;
                    any     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axi3_wr_arbiter.sv
// Shares one AXI3 master write port between NUM_REQ requesters, round-robin,
// holding each grant across the address, every data beat and the response.
module axi3_wr_arbiter
    import axi3_arb_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int SIZE      = 3,
    parameter int ID_W      = DEF_ID_W,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int NUM_REQ   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*DATAWIDTH-1:0]     req_awaddr,
    input  logic [NUM_REQ*ID_W-1:0]          req_awid,
    input  logic [NUM_REQ*LEN_W-1:0]         req_awlen,
    input  logic [NUM_REQ*SIZE-1:0]          req_awsize,
    input  logic [NUM_REQ*(SIZE-1)-1:0]      req_awburst,
    output logic [NUM_REQ-1:0]               req_grant,
    input  logic [NUM_REQ*DATAWIDTH-1:0]     req_wdata,
    input  logic [NUM_REQ*(DATAWIDTH/8)-1:0] req_wstrb,
    input  logic [NUM_REQ-1:0]               req_wvalid,
    output logic [NUM_REQ-1:0]               req_wready,
    output logic [NUM_REQ-1:0]               req_bvalid,
    output logic [1:0]                       req_bresp,
    input  logic [NUM_REQ-1:0]               req_bready,
    output logic [DATAWIDTH-1:0]             AWaddr,
    output logic [ID_W-1:0]                  AWid,
    output logic [LEN_W-1:0]                 AWlen,
    output logic [SIZE-1:0]                  AWsize,
    output logic [SIZE-2:0]                  AWburst,
    output logic                             AWvalid,
    input  logic                             AWready,
    output logic [DATAWIDTH-1:0]             WData,
    output logic [DATAWIDTH/8-1:0]           WStrb,
    output logic                             WLast,
    output logic                             WValid,
    input  logic                             WReady,
    input  logic [ID_W-1:0]                  Bid,
    input  logic [1:0]                       Bresp,
    input  logic                             BValid,
    output logic                             BReady,
    output logic                             err_id
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STRB_W = DATAWIDTH / 8;

    arb_state_e          state;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    ptr_nxt;
    logic [NUM_REQ-1:0]  grant_q;
    logic [NUM_REQ-1:0]  pick;
    logic                pick_any;
    logic [LEN_W-1:0]    beat_cnt;

    logic [DATAWIDTH-1:0] aw_addr_q;
    logic [ID_W-1:0]      aw_id_q;
    logic [LEN_W-1:0]     aw_len_q;
    logic [SIZE-1:0]      aw_size_q;
    logic [SIZE-2:0]      aw_burst_q;

    logic [DATAWIDTH-1:0] sel_addr;
    logic [ID_W-1:0]      sel_id;
    logic [LEN_W-1:0]     sel_len;
    logic [SIZE-1:0]      sel_size;
    logic [SIZE-2:0]      sel_burst;

    logic                 g_wvalid;
    logic [DATAWIDTH-1:0] g_wdata;
    logic [STRB_W-1:0]    g_wstrb;
    logic                 g_bready;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .pick      (pick),
        .any       (pick_any)
    );

    // Candidate AW fields follow the pick; the granted side's W/B signals follow grant_q.
    always_comb begin
        sel_addr  = '0;
        sel_id    = '0;
        sel_len   = '0;
        sel_size  = '0;
        sel_burst = '0;
        g_wvalid  = 1'b0;
        g_wdata   = '0;
        g_wstrb   = '0;
        g_bready  = 1'b0;
        ptr_nxt   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick[j]) begin
                sel_addr  = req_awaddr[j*DATAWIDTH +: DATAWIDTH];
                sel_id    = req_awid[j*ID_W +: ID_W];
                sel_len   = req_awlen[j*LEN_W +: LEN_W];
                sel_size  = req_awsize[j*SIZE +: SIZE];
                sel_burst = req_awburst[j*(SIZE-1) +: (SIZE-1)];
            end
            if (grant_q[j]) begin
                g_wvalid = req_wvalid[j];
                g_wdata  = req_wdata[j*DATAWIDTH +: DATAWIDTH];
                g_wstrb  = req_wstrb[j*STRB_W +: STRB_W];
                g_bready = req_bready[j];
                ptr_nxt  = PTR_W'((j + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            state      <= IDLE;
            ptr        <= '0;
            grant_q    <= '0;
            beat_cnt   <= '0;
            aw_addr_q  <= '0;
            aw_id_q    <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
        end else begin
            case (state)
                IDLE: if (pick_any) begin
                    grant_q    <= pick;
                    aw_addr_q  <= sel_addr;
                    aw_id_q    <= sel_id;
                    aw_len_q   <= sel_len;
                    aw_size_q  <= sel_size;
                    aw_burst_q <= sel_burst;
                    state      <= ADDR;
                end
                ADDR: if (AWready) begin
                    beat_cnt <= aw_len_q;
                    state    <= DATA;
                end
                DATA: if (WValid && WReady) begin
                    if (beat_cnt == '0) state <= RESP;
                    else                beat_cnt <= beat_cnt - LEN_W'(1);
                end
                RESP: if (BValid && BReady) begin
                    grant_q <= '0;
                    ptr     <= ptr_nxt;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_grant = grant_q;
    assign AWaddr    = aw_addr_q;
    assign AWid      = aw_id_q;
    assign AWlen     = aw_len_q;
    assign AWsize    = aw_size_q;
    assign AWburst   = aw_burst_q;
    assign AWvalid   = (state == ADDR);

    assign WValid     = (state == DATA) && g_wvalid;
    assign WData      = g_wdata;
    assign WStrb      = g_wstrb;
    assign WLast      = (state == DATA) && (beat_cnt == '0);
    assign req_wready = ((state == DATA) && WReady) ? grant_q : '0;

    assign BReady     = (state == RESP) && g_bready;
    assign req_bvalid = ((state == RESP) && BValid) ? grant_q : '0;
    assign req_bresp  = Bresp;
    // Mismatched IDs still complete the transaction; the flag only reports it.
    assign err_id     = (state == RESP) && BValid && BReady && (Bid != aw_id_q);

endmodule

// File: tb/tb_axi3_wr_arbiter.sv
// Self-checking bench for axi3_wr_arbiter: a round-robin vector table plus
// hand-written sequences for reset, stalls, ID errors and non-granted traffic.
module tb_axi3_wr_arbiter;
    import axi3_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid;
    logic [63:0] req_awaddr;
    logic [7:0]  req_awid;
    logic [7:0]  req_awlen;
    logic [5:0]  req_awsize;
    logic [3:0]  req_awburst;
    logic [1:0]  req_grant;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic [1:0]  req_wvalid;
    logic [1:0]  req_wready;
    logic [1:0]  req_bvalid;
    logic [1:0]  req_bresp;
    logic [1:0]  req_bready;
    logic [31:0] AWaddr;
    logic [3:0]  AWid;
    logic [3:0]  AWlen;
    logic [2:0]  AWsize;
    logic [1:0]  AWburst;
    logic        AWvalid;
    logic        AWready;
    logic [31:0] WData;
    logic [3:0]  WStrb;
    logic        WLast;
    logic        WValid;
    logic        WReady;
    logic [3:0]  Bid;
    logic [1:0]  Bresp;
    logic        BValid;
    logic        BReady;
    logic        err_id;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi3_wr_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_awaddr  (req_awaddr),
        .req_awid    (req_awid),
        .req_awlen   (req_awlen),
        .req_awsize  (req_awsize),
        .req_awburst (req_awburst),
        .req_grant   (req_grant),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .req_wvalid  (req_wvalid),
        .req_wready  (req_wready),
        .req_bvalid  (req_bvalid),
        .req_bresp   (req_bresp),
        .req_bready  (req_bready),
        .AWaddr      (AWaddr),
        .AWid        (AWid),
        .AWlen       (AWlen),
        .AWsize      (AWsize),
        .AWburst     (AWburst),
        .AWvalid     (AWvalid),
        .AWready     (AWready),
        .WData       (WData),
        .WStrb       (WStrb),
        .WLast       (WLast),
        .WValid      (WValid),
        .WReady      (WReady),
        .Bid         (Bid),
        .Bresp       (Bresp),
        .BValid      (BValid),
        .BReady      (BReady),
        .err_id      (err_id)
    );

    typedef struct {
        logic [1:0] valid;
        logic [3:0] len;
        logic [3:0] id;
        logic [3:0] bid;
        logic [1:0] bresp;
        logic [1:0] exp_grant;
        logic       exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] beat_data(input int r, input int b);
        return 32'(32'hA000_0000 | (r << 8) | b);
    endfunction

    function automatic logic [1:0] onehot(input int r);
        return (r == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic set_aw(input int r, input logic [31:0] addr, input logic [3:0] id,
                          input logic [3:0] len);
        req_awaddr[r*32 +: 32] = addr;
        req_awid[r*4 +: 4]     = id;
        req_awlen[r*4 +: 4]    = len;
        req_awsize[r*3 +: 3]   = (r == 0) ? 3'd2 : 3'd1;
        req_awburst[r*2 +: 2]  = (r == 0) ? 2'b01 : 2'b00;
    endtask

    task automatic expect_grant(input int r, input logic [31:0] addr, input logic [3:0] id,
                                input logic [3:0] len);
        check("grant", req_grant, onehot(r));
        check("awvalid_on_grant", AWvalid, 1);
        check("awaddr", AWaddr, addr);
        check("awid", AWid, id);
        check("awlen", AWlen, len);
        check("awsize", AWsize, (r == 0) ? 3'd2 : 3'd1);
        check("awburst", AWburst, (r == 0) ? 2'b01 : 2'b00);
    endtask

    task automatic resp_phase(input int r, input logic [3:0] bid, input logic [1:0] bresp,
                              input logic exp_err);
        BValid     = 1'b1;
        Bid        = bid;
        Bresp      = bresp;
        req_bready = 2'b00;
        settle();
        check("bready_held", BReady, 0);
        check("err_id_no_handshake", err_id, 0);
        check("req_bvalid", req_bvalid, onehot(r));
        tick();
        req_bready[r] = 1'b1;
        settle();
        check("bready", BReady, 1);
        check("req_bvalid_hs", req_bvalid, onehot(r));
        check("req_bresp", req_bresp, bresp);
        check("err_id_hs", err_id, exp_err);
        tick();
        BValid     = 1'b0;
        req_bready = 2'b00;
        settle();
        check("err_id_after", err_id, 0);
        check("grant_cleared", req_grant, 0);
        check("awvalid_idle", AWvalid, 0);
    endtask

    task automatic finish_txn(input int r, input logic [3:0] len, input logic [3:0] bid,
                              input logic [1:0] bresp, input logic exp_err);
        req_valid[r] = 1'b0;
        AWready      = 1'b1;
        settle();
        check("awvalid_before_hs", AWvalid, 1);
        tick();
        AWready = 1'b0;
        WReady  = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            req_wvalid[r]          = 1'b1;
            req_wdata[r*32 +: 32]  = beat_data(r, b);
            settle();
            check("wvalid", WValid, 1);
            check("wdata", WData, beat_data(r, b));
            check("wstrb", WStrb, (r == 0) ? 4'hF : 4'h3);
            check("wlast", WLast, (b == int'(len)) ? 1 : 0);
            check("req_wready", req_wready, onehot(r));
            tick();
        end
        req_wvalid[r] = 1'b0;
        WReady        = 1'b0;
        resp_phase(r, bid, bresp, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded its time limit at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int beat;
        int r;

        vecs[0] = '{2'b11, 4'd0, 4'h1, 4'h1, OKAY,   2'b10, 1'b0};
        vecs[1] = '{2'b11, 4'd2, 4'h4, 4'h4, EXOKAY, 2'b01, 1'b0};
        vecs[2] = '{2'b01, 4'd0, 4'h7, 4'h8, DECERR, 2'b01, 1'b1};
        vecs[3] = '{2'b10, 4'd1, 4'hF, 4'hF, OKAY,   2'b10, 1'b0};
        vecs[4] = '{2'b01, 4'd0, 4'h0, 4'h0, SLVERR, 2'b01, 1'b0};
        vecs[5] = '{2'b11, 4'd0, 4'hA, 4'hA, OKAY,   2'b10, 1'b0};

        req_valid   = '0;
        req_awaddr  = '0;
        req_awid    = '0;
        req_awlen   = '0;
        req_awsize  = '0;
        req_awburst = '0;
        req_wdata   = '0;
        req_wstrb   = 8'h3F;
        req_wvalid  = '0;
        req_bready  = '0;
        AWready     = 1'b0;
        WReady      = 1'b0;
        Bid         = '0;
        Bresp       = '0;
        BValid      = 1'b0;
        beat        = 0;
        r           = 0;

        repeat (2) tick();
        check("rst_grant", req_grant, 0);
        check("rst_awvalid", AWvalid, 0);
        check("rst_wvalid", WValid, 0);
        check("rst_bready", BReady, 0);
        check("rst_err_id", err_id, 0);
        check("rst_awaddr", AWaddr, 0);
        check("rst_awid", AWid, 0);
        check("rst_awlen", AWlen, 0);
        rst = 1'b1;

        // Move the pointer to 1, then reset in the middle of requester 1's burst.
        set_aw(0, 32'h0000_0040, 4'h1, 4'd0);
        req_valid = 2'b01;
        settle();
        check("no_grant_same_cycle", req_grant, 0);
        tick();
        expect_grant(0, 32'h0000_0040, 4'h1, 4'd0);
        finish_txn(0, 4'd0, 4'h1, OKAY, 1'b0);

        set_aw(1, 32'h0000_0080, 4'h2, 4'd3);
        req_valid = 2'b10;
        tick();
        expect_grant(1, 32'h0000_0080, 4'h2, 4'd3);
        req_valid  = 2'b00;
        AWready    = 1'b1;
        tick();
        AWready    = 1'b0;
        WReady     = 1'b1;
        req_wvalid = 2'b10;
        settle();
        check("midburst_wvalid", WValid, 1);
        tick();
        rst = 1'b0;
        settle();
        check("async_rst_valids", {AWvalid, WValid, BReady, req_grant}, 0);
        check("async_rst_awaddr", AWaddr, 0);
        WReady     = 1'b0;
        req_wvalid = 2'b00;
        tick();

        // Simultaneous requests from reset: 0 first, an IDLE gap, then 1, then 0 again.
        set_aw(0, 32'h0000_0500, 4'h3, 4'd0);
        set_aw(1, 32'h0000_0600, 4'h4, 4'd0);
        req_valid = 2'b11;
        rst       = 1'b1;
        tick();
        expect_grant(0, 32'h0000_0500, 4'h3, 4'd0);
        finish_txn(0, 4'd0, 4'h3, OKAY, 1'b0);
        tick();
        expect_grant(1, 32'h0000_0600, 4'h4, 4'd0);
        finish_txn(1, 4'd0, 4'h4, OKAY, 1'b0);
        req_valid = 2'b11;
        tick();
        expect_grant(0, 32'h0000_0500, 4'h3, 4'd0);
        finish_txn(0, 4'd0, 4'h3, OKAY, 1'b0);
        req_valid = 2'b00;

        // Round-robin table, starting with the pointer at 1.
        for (int i = 0; i < 6; i++) begin
            r = vecs[i].exp_grant[1] ? 1 : 0;
            set_aw(0, 32'(32'h1000_0000 + i * 16), vecs[i].id, vecs[i].len);
            set_aw(1, 32'(32'h2000_0000 + i * 16), vecs[i].id, vecs[i].len);
            req_valid = vecs[i].valid;
            tick();
            expect_grant(r, (r == 1) ? 32'(32'h2000_0000 + i * 16) : 32'(32'h1000_0000 + i * 16),
                         vecs[i].id, vecs[i].len);
            finish_txn(r, vecs[i].len, vecs[i].bid, vecs[i].bresp, vecs[i].exp_err);
            req_valid = 2'b00;
        end

        // Four-beat burst from requester 0 alone.
        set_aw(0, 32'h0000_1000, 4'h1, 4'd3);
        req_valid = 2'b01;
        settle();
        check("awvalid_latency_n", AWvalid, 0);
        tick();
        expect_grant(0, 32'h0000_1000, 4'h1, 4'd3);
        finish_txn(0, 4'd3, 4'h1, OKAY, 1'b0);

        // AW stalled five cycles, then W stalls with WReady 1,0,1 on a two-beat burst.
        set_aw(0, 32'h0000_2000, 4'h2, 4'd1);
        req_valid = 2'b01;
        tick();
        expect_grant(0, 32'h0000_2000, 4'h2, 4'd1);
        req_valid          = 2'b00;
        req_wvalid[0]      = 1'b1;
        req_wdata[31:0]    = beat_data(0, 0);
        WReady             = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_awaddr[31:0] = 32'(32'h0000_2000 + i + 1);
            settle();
            check("aw_stall_awvalid", AWvalid, 1);
            check("aw_stall_awaddr", AWaddr, 32'h0000_2000);
            check("aw_stall_awlen", AWlen, 4'd1);
            check("aw_stall_no_w", WValid, 0);
            check("aw_stall_no_wready", req_wready, 0);
            tick();
        end
        AWready = 1'b1;
        settle();
        tick();
        AWready = 1'b0;
        beat    = 0;
        for (int c = 0; c < 3; c++) begin
            WReady          = (c != 1);
            req_wdata[31:0] = beat_data(0, beat);
            settle();
            check("wstall_wvalid", WValid, 1);
            check("wstall_wdata", WData, beat_data(0, beat));
            check("wstall_wlast", WLast, (beat == 1) ? 1 : 0);
            check("wstall_wready", req_wready, (c != 1) ? 2'b01 : 2'b00);
            if (c != 1) beat++;
            tick();
        end
        settle();
        check("no_extra_beat", WValid, 0);
        req_wvalid = 2'b00;
        WReady     = 1'b0;
        resp_phase(0, 4'h2, OKAY, 1'b0);

        // Single beat with a mismatched response ID and SLVERR.
        set_aw(0, 32'h0000_3000, 4'h5, 4'd0);
        req_valid = 2'b01;
        tick();
        expect_grant(0, 32'h0000_3000, 4'h5, 4'd0);
        finish_txn(0, 4'd0, 4'h6, SLVERR, 1'b1);

        // Requester 1 drives W and new AW fields while requester 0 owns the port.
        set_aw(0, 32'h0000_4000, 4'h3, 4'd2);
        req_valid = 2'b01;
        tick();
        expect_grant(0, 32'h0000_4000, 4'h3, 4'd2);
        set_aw(1, 32'h0000_9990, 4'h9, 4'd1);
        set_aw(0, 32'h0000_7770, 4'hE, 4'd0);
        req_valid        = 2'b11;
        req_wvalid[1]    = 1'b1;
        req_wdata[63:32] = 32'hBAD0_0001;
        finish_txn(0, 4'd2, 4'h3, OKAY, 1'b0);
        check("latched_awaddr_kept", AWaddr, 32'h0000_4000);
        check("latched_awid_kept", AWid, 4'h3);
        tick();
        expect_grant(1, 32'h0000_9990, 4'h9, 4'd1);
        finish_txn(1, 4'd1, 4'h9, OKAY, 1'b0);
        req_valid = 2'b00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
